// File: rtl/sobel_pkg.sv
// Shared parameters for the Sobel window generator: default frame size,
// pixel and coordinate widths.
package sobel_pkg;

  localparam int IMG_W_DEF = 320;
  localparam int IMG_H_DEF = 240;
  localparam int PIX_W     = 8;
  localparam int CX_W      = 9;
  localparam int CY_W      = 8;
  localparam int WIN_W     = 9 * PIX_W;

  typedef logic [PIX_W-1:0] pix_t;

endpackage

// File: rtl/line_buffer.sv
// Single-port-per-direction line store: one write and one registered read
// per cycle. A read and a write to the same address in the same cycle
// returns the old contents. Contents are not reset.
module line_buffer #(
  parameter int DEPTH = 320,
  parameter int AW    = 9,
  parameter int DW    = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  // Write port and registered read port; the read sees pre-write data.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/sobel_window_gen.sv
// Streams raster-order grayscale pixels into a 3x3 neighbourhood window.
// Stage 0 (accept edge): coordinates resolved, line buffers read, LB0 written.
// Stage 1: LB1 written with the row that just left LB0, window shifts left.
// Stage 2: window and centre copied to the outputs with win_valid.
// A restart (sof) kills every window still in flight so nothing from the
// previous frame is ever presented after the new frame begins.
module sobel_window_gen
  import sobel_pkg::*;
#(
  parameter int IMG_W = IMG_W_DEF,
  parameter int IMG_H = IMG_H_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pix_valid,
  input  logic [PIX_W-1:0] pix_in,
  input  logic             sof,
  output logic             win_valid,
  output logic [WIN_W-1:0] win,
  output logic [CX_W-1:0]  cen_x,
  output logic [CY_W-1:0]  cen_y,
  output logic             eof
);

  localparam logic [CX_W-1:0] X_LAST = CX_W'(IMG_W - 1);
  localparam logic [CY_W-1:0] Y_LAST = CY_W'(IMG_H - 1);

  // Next-pixel coordinates
  logic [CX_W-1:0] x_reg;
  logic [CY_W-1:0] y_reg;
  // Coordinates of the pixel presented this cycle
  logic [CX_W-1:0] cur_x;
  logic [CY_W-1:0] cur_y;
  logic            restart;

  // Stage 1
  logic             s1_valid;
  logic [CX_W-1:0]  s1_x;
  pix_t             s1_pix;
  logic             s1_ok;
  logic             s1_eof;
  logic [CX_W-1:0]  s1_cx;
  logic [CY_W-1:0]  s1_cy;

  // Stage 2
  logic             s2_ok;
  logic             s2_eof;
  logic [CX_W-1:0]  s2_cx;
  logic [CY_W-1:0]  s2_cy;

  pix_t             lb0_rd;
  pix_t             lb1_rd;
  pix_t             tap [3][3];
  logic [WIN_W-1:0] win_packed;

  assign restart = pix_valid & sof;

  // A start-of-frame pixel is always (0,0) whatever the counters say.
  always_comb begin
    cur_x = x_reg;
    cur_y = y_reg;
    if (sof) begin
      cur_x = '0;
      cur_y = '0;
    end
  end

  // Raster position counters, advanced only on accepted pixels.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_reg <= '0;
      y_reg <= '0;
    end else if (pix_valid) begin
      if (cur_x == X_LAST) begin
        x_reg <= '0;
        y_reg <= (cur_y == Y_LAST) ? '0 : cur_y + 1'b1;
      end else begin
        x_reg <= cur_x + 1'b1;
        y_reg <= cur_y;
      end
    end
  end

  // Stage 1 capture: pixel, column address and window bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_x     <= '0;
      s1_pix   <= '0;
      s1_ok    <= 1'b0;
      s1_eof   <= 1'b0;
      s1_cx    <= '0;
      s1_cy    <= '0;
    end else begin
      s1_valid <= pix_valid;
      if (pix_valid) begin
        s1_x   <= cur_x;
        s1_pix <= pix_in;
        s1_ok  <= (cur_x >= CX_W'(2)) && (cur_y >= CY_W'(2));
        s1_eof <= (cur_x == X_LAST) && (cur_y == Y_LAST);
        s1_cx  <= cur_x - 1'b1;
        s1_cy  <= cur_y - 1'b1;
      end
    end
  end

  // LB0 holds row y-1: read old value at x, then overwrite with row y.
  line_buffer #(.DEPTH(IMG_W), .AW(CX_W), .DW(PIX_W)) u_lb0 (
    .clk   (clk),
    .we    (pix_valid),
    .waddr (cur_x),
    .wdata (pix_in),
    .re    (pix_valid),
    .raddr (cur_x),
    .rdata (lb0_rd)
  );

  // LB1 holds row y-2: refilled one cycle later with what LB0 returned.
  line_buffer #(.DEPTH(IMG_W), .AW(CX_W), .DW(PIX_W)) u_lb1 (
    .clk   (clk),
    .we    (s1_valid),
    .waddr (s1_x),
    .wdata (lb0_rd),
    .re    (pix_valid),
    .raddr (cur_x),
    .rdata (lb1_rd)
  );

  // Window shift: columns move left, new right column is rows y-2, y-1, y.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          tap[r][c] <= '0;
        end
      end
    end else if (s1_valid) begin
      for (int r = 0; r < 3; r++) begin
        tap[r][0] <= tap[r][1];
        tap[r][1] <= tap[r][2];
      end
      tap[0][2] <= lb1_rd;
      tap[1][2] <= lb0_rd;
      tap[2][2] <= s1_pix;
    end
  end

  // Row-major packing, w00 in the top byte.
  genvar gi;
  generate
    for (gi = 0; gi < 9; gi++) begin : g_tap
      assign win_packed[WIN_W-1-gi*PIX_W -: PIX_W] = tap[gi/3][gi%3];
    end
  endgenerate

  // Stage 2: one-shot window flag; a restart cancels the old frame's window.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_ok  <= 1'b0;
      s2_eof <= 1'b0;
      s2_cx  <= '0;
      s2_cy  <= '0;
    end else begin
      s2_ok <= s1_valid & s1_ok & ~restart;
      if (s1_valid) begin
        s2_eof <= s1_eof;
        s2_cx  <= s1_cx;
        s2_cy  <= s1_cy;
      end
    end
  end

  // Output registers only load on a valid window, otherwise they hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_valid <= 1'b0;
      eof       <= 1'b0;
      win       <= '0;
      cen_x     <= '0;
      cen_y     <= '0;
    end else begin
      win_valid <= s2_ok & ~restart;
      eof       <= s2_ok & s2_eof & ~restart;
      if (s2_ok && !restart) begin
        win   <= win_packed;
        cen_x <= s2_cx;
        cen_y <= s2_cy;
      end
    end
  end

endmodule

// File: tb/tb_sobel_window_gen.sv
// Directed bench for sobel_window_gen on a small 8x6 frame.
module tb_sobel_window_gen;

  localparam int W = 8;
  localparam int H = 6;

  logic        clk;
  logic        rst;
  logic        pix_valid;
  logic [7:0]  pix_in;
  logic        sof;
  logic        win_valid;
  logic [71:0] win;
  logic [8:0]  cen_x;
  logic [7:0]  cen_y;
  logic        eof;

  sobel_window_gen #(.IMG_W(W), .IMG_H(H)) dut (
    .clk       (clk),
    .rst       (rst),
    .pix_valid (pix_valid),
    .pix_in    (pix_in),
    .sof       (sof),
    .win_valid (win_valid),
    .win       (win),
    .cen_x     (cen_x),
    .cen_y     (cen_y),
    .eof       (eof)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int mode = 0;
  int mx = 0;
  int my = 0;
  int win_cnt = 0;
  int eof_cnt = 0;
  bit got_first = 0;
  bit mon_en = 0;
  logic [71:0] first_win;
  logic [16:0] first_cen;
  logic [71:0] prev_win;
  logic [7:0]  pm [H][W];
  int          acc_cyc [H][W];

  localparam logic [71:0] RAMP_FIRST = 72'h000102_010203_020304;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] pix_of(input int m, input int x, input int y);
    case (m)
      0:       return 8'((x + y) & 255);
      1:       return 8'((x * 7 + y * 13 + 64) & 255);
      default: return 8'hAA;
    endcase
  endfunction

  // Monitor: every window is checked against the stored frame.
  always @(negedge clk) begin
    if (rst) begin
      prev_win = win;
    end else if (mon_en) begin
      if (win_valid) begin
        int cx;
        int cy;
        logic [71:0] exp_w;
        cx = int'(cen_x);
        cy = int'(cen_y);
        win_cnt++;
        if (!got_first) begin
          got_first = 1;
          first_win = win;
          first_cen = {cen_x, cen_y};
        end
        check("cen_range", 72'(cx >= 1 && cx <= W - 2 && cy >= 1 && cy <= H - 2), 72'd1);
        if (cx >= 1 && cx <= W - 2 && cy >= 1 && cy <= H - 2) begin
          exp_w = '0;
          for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
              exp_w[71 - (r * 3 + c) * 8 -: 8] = pm[cy - 1 + r][cx - 1 + c];
          check("win", win, exp_w);
          check("latency", 72'(cyc), 72'(acc_cyc[cy + 1][cx + 1] + 2));
        end
      end else begin
        check("hold", win, prev_win);
      end
      if (eof) begin
        eof_cnt++;
        check("eof_valid", 72'(win_valid), 72'd1);
        check("eof_cen", 72'({cen_x, cen_y}), 72'({9'(W - 2), 8'(H - 2)}));
      end
      prev_win = win;
    end
  end

  task automatic idle(input int n);
    pix_valid = 1'b0;
    sof = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input bit s, input bit gaps);
    logic [7:0] v;
    if (gaps) begin
      while ($urandom_range(0, 1) == 1) begin
        pix_valid = 1'b0;
        sof = 1'b0;
        pix_in = 8'($urandom);
        @(posedge clk);
        #1;
      end
    end
    if (s) begin
      mx = 0;
      my = 0;
    end
    v = pix_of(mode, mx, my);
    pix_valid = 1'b1;
    sof = s;
    pix_in = v;
    @(posedge clk);
    #1;
    pm[my][mx] = v;
    acc_cyc[my][mx] = cyc;
    if (s) begin
      win_cnt = 0;
      eof_cnt = 0;
      got_first = 0;
    end
    pix_valid = 1'b0;
    sof = 1'b0;
    mx++;
    if (mx == W) begin
      mx = 0;
      my++;
      if (my == H) my = 0;
    end
  endtask

  task automatic send_pixels(input bit first_sof, input bit gaps, input int n);
    for (int i = 0; i < n; i++) send(first_sof && (i == 0), gaps);
  endtask

  initial begin
    rst = 1'b1;
    pix_valid = 1'b0;
    sof = 1'b0;
    pix_in = 8'h00;
    prev_win = '0;
    @(posedge clk);
    #1;
    check("rst_win_valid", 72'(win_valid), 72'd0);
    check("rst_eof", 72'(eof), 72'd0);
    check("rst_win", win, 72'd0);
    check("rst_cen", 72'({cen_x, cen_y}), 72'd0);
    rst = 1'b0;
    mon_en = 1;

    // Ramp frame, continuous
    mode = 0;
    send_pixels(1, 0, W * H);
    idle(5);
    $display("ramp frame: windows=%0d eof=%0d", win_cnt, eof_cnt);
    check("ramp_first_win", first_win, RAMP_FIRST);
    check("ramp_first_cen", 72'(first_cen), 72'({9'd1, 8'd1}));
    check("ramp_count", 72'(win_cnt), 72'((W - 2) * (H - 2)));
    check("ramp_eof_count", 72'(eof_cnt), 72'd1);

    // Different pattern, random input gaps
    mode = 1;
    send_pixels(1, 1, W * H);
    idle(5);
    $display("gapped frame: windows=%0d eof=%0d", win_cnt, eof_cnt);
    check("gap_count", 72'(win_cnt), 72'((W - 2) * (H - 2)));
    check("gap_eof_count", 72'(eof_cnt), 72'd1);

    // Partial frame, then sof mid-frame restarts with ramp values
    mode = 1;
    send_pixels(1, 0, 3 * W + 6);
    mode = 0;
    send_pixels(1, 0, W * H);
    idle(5);
    $display("sof restart frame: windows=%0d eof=%0d", win_cnt, eof_cnt);
    check("sof_first_win", first_win, RAMP_FIRST);
    check("sof_first_cen", 72'(first_cen), 72'({9'd1, 8'd1}));
    check("sof_count", 72'(win_cnt), 72'((W - 2) * (H - 2)));
    check("sof_eof_count", 72'(eof_cnt), 72'd1);

    // Reset mid-line, then restart without sof
    mode = 1;
    send_pixels(1, 0, 3 * W + 5);
    rst = 1'b1;
    #1;
    check("midrst_win_valid", 72'(win_valid), 72'd0);
    check("midrst_win", win, 72'd0);
    check("midrst_cen", 72'({cen_x, cen_y}), 72'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    mx = 0;
    my = 0;
    win_cnt = 0;
    eof_cnt = 0;
    got_first = 0;
    mode = 0;
    send_pixels(0, 0, W * H);
    idle(5);
    $display("post-reset frame: windows=%0d eof=%0d", win_cnt, eof_cnt);
    check("rst_first_win", first_win, RAMP_FIRST);
    check("rst_first_cen", 72'(first_cen), 72'({9'd1, 8'd1}));
    check("rst_count", 72'(win_cnt), 72'((W - 2) * (H - 2)));

    // Constant frame
    mode = 2;
    send_pixels(1, 0, W * H);
    idle(5);
    $display("constant frame: windows=%0d eof=%0d", win_cnt, eof_cnt);
    check("const_first_win", first_win, {9{8'hAA}});
    check("const_count", 72'(win_cnt), 72'((W - 2) * (H - 2)));
    check("const_eof_count", 72'(eof_cnt), 72'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sobel_window_gen.md
SOBEL_WINDOW_GEN -- requirements
Module: sobel_window_gen

Interface
REQ-001 SHALL have parameter IMG_W, default 320, pixels per line.
REQ-002 SHALL have parameter IMG_H, default 240, lines per frame.
REQ-003 SHALL have port clk  input  1  single clock; all logic rising-edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port pix_valid  input  1  pix_in carries a pixel this cycle.
REQ-006 SHALL have port pix_in  input  8  grayscale pixel, raster order.
REQ-007 SHALL have port sof  input  1  qualified by pix_valid; pixel is (0,0) of a new frame.
REQ-008 SHALL have port win_valid  output  1  win/cen_x/cen_y hold a valid 3x3 window.
REQ-009 SHALL have port win  output  72  taps w00..w22, row-major; w00 in [71:64] (top-left), w22 in [7:0] (bottom-right).
REQ-010 SHALL have port cen_x  output  9  window centre column.
REQ-011 SHALL have port cen_y  output  8  window centre row.
REQ-012 SHALL have port eof  output  1  one-cycle pulse with the last window of a frame.

Function
REQ-013 SHALL keep counters x (0..IMG_W-1) and y (0..IMG_H-1), advanced only on accepted pixels (pix_valid=1).
REQ-014 SHALL wrap x to 0 and increment y after x=IMG_W-1; after (IMG_W-1,IMG_H-1) SHALL wrap to (0,0).
REQ-015 SHALL, on pix_valid&sof, treat the pixel as (0,0) regardless of counter state; next pixel is (1,0).
REQ-016 SHALL use two line buffers (IMG_W x 8): LB0 holds row y-1, LB1 holds row y-2.
REQ-017 SHALL, on accepting (x,y), read LB0[x] and LB1[x] and write pix_in to LB0[x] in the same cycle; read returns the old contents (read-before-write), 1-cycle latency.
REQ-018 SHALL write LB0 read data into LB1[x] one cycle after acceptance.
REQ-019 SHALL shift a 3x3 register window one column left when the stage-1 valid flag is set, new right column = {LB1 data, LB0 data, delayed pixel} top to bottom.
REQ-020 SHALL assert win_valid for exactly one cycle per accepted pixel with x>=2 and y>=2, centre = (x-1,y-1).
REQ-021 SHALL present win_valid 2 clock edges after the edge sampling the pixel (fixed latency 2), independent of input gaps.
REQ-022 SHALL produce no window for border centres (column 0, IMG_W-1; row 0, IMG_H-1); (IMG_W-2)*(IMG_H-2) windows per complete frame.
REQ-023 SHALL pulse eof together with the window centred at (IMG_W-2,IMG_H-2).
REQ-024 SHALL hold win, cen_x, cen_y unchanged while win_valid=0.
REQ-025 SHALL accept pix_valid back-to-back every cycle; no backpressure exists.
REQ-026 SHALL, on sof mid-frame, suppress windows until new (2,2); stale line-buffer data never reaches a valid window.

Reset
REQ-027 SHALL on rst force x=0, y=0, pipeline valids=0, win_valid=0, eof=0, win=0, cen_x=0, cen_y=0.
REQ-028 SHALL NOT reset line-buffer contents; rst mid-frame discards in-flight pixels and next pixel is (0,0).

Structure
REQ-029 SHALL take IMG_W, IMG_H, pixel width 8 and coordinate widths from the shared sobel parameter package/include.
REQ-030 SHALL instantiate existing line_buffer twice (LB0, LB1) as the only sub-module; counters, window registers, control inline.

Verification
REQ-031 Ramp frame pix=(x+y)&0xFF, continuous -> first win_valid 2 cycles after (2,2); cen=(1,1); win rows {0,1,2},{1,2,3},{2,3,4}.
REQ-032 Full 320x240 frame, random pix_valid gaps (50%) -> exactly 75684 windows, all match golden model, one eof at cen=(318,238).
REQ-033 Two frames back-to-back, second with sof -> second-frame first window cen=(1,1) with only second-frame pixel values.
REQ-034 sof asserted at (150,100) -> no win_valid until new (2,2); then cen=(1,1), correct values.
REQ-035 rst asserted mid-line at (77,50) -> next cycle win_valid=0, win=0; restart from pixel (0,0) reproduces REQ-031 result.
REQ-036 Constant pix=0xAA frame -> every window all taps 0xAA; win_valid never at centre x=0/319 or y=0/239.
